// File: rtl/ram8_fifo_ctrl_if.sv
// Valid/ready stream pair for the FIFO controller: write side (in_*) and read side (out_*).
interface ram8_fifo_ctrl_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/ram8_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM bank plus one output holding register.
// One RAM access per clock; simultaneous write/read requests are served round-robin.
module ram8_fifo_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  ram8_fifo_ctrl_if.slave   s,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out,
  output logic [ADDR_W-1:0] ram_add,
  output logic              ram_read,
  output logic              ram_write,
  output logic              ram_en,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  typedef enum logic {GNT_RD = 1'b0, GNT_WR = 1'b1} grant_e;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_vld_q, out_vld_d;
  grant_e            last_q, last_d;

  logic wreq, rreq, gnt_wr, gnt_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      last_q     <= GNT_RD;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    wreq   = s.in_valid & (cnt_q != DEPTH);
    rreq   = (cnt_q != '0) & (~out_vld_q | s.out_ready);
    // On contention the side that lost last time wins; reset blocks every grant.
    gnt_wr = ~reset & wreq & (~rreq | (last_q == GNT_RD));
    gnt_rd = ~reset & rreq & ~gnt_wr;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    last_d     = last_q;
    ram_en     = 1'b0;
    ram_read   = 1'b0;
    ram_write  = 1'b0;
    ram_add    = rd_ptr_q;

    if (out_vld_q && s.out_ready) begin
      out_vld_d = 1'b0;
    end

    if (gnt_wr) begin
      ram_en    = 1'b1;
      ram_write = 1'b1;
      ram_add   = wr_ptr_q;
      wr_ptr_d  = wr_ptr_q + 1'b1;
      cnt_d     = cnt_q + 1'b1;
      last_d    = GNT_WR;
    end else if (gnt_rd) begin
      ram_en     = 1'b1;
      ram_read   = 1'b1;
      ram_add    = rd_ptr_q;
      rd_ptr_d   = rd_ptr_q + 1'b1;
      cnt_d      = cnt_q - 1'b1;
      out_data_d = ram_out;
      out_vld_d  = 1'b1;
      last_d     = GNT_RD;
    end
  end

  assign s.in_ready  = gnt_wr;
  assign s.out_data  = out_data_q;
  assign s.out_valid = out_vld_q;
  assign ram_in      = s.in_data;
  assign level       = cnt_q + {{ADDR_W{1'b0}}, out_vld_q};
  assign full        = (cnt_q == DEPTH);
  assign empty       = (level == '0);

endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// Bench for ram8_fifo_ctrl: behavioural RAM, queue-based scoreboard and directed/random phases.
module tb_ram8_fifo_ctrl;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram8_fifo_ctrl_if #(.DATA_W(DATA_W)) bus ();

  logic [DATA_W-1:0] ram_in, ram_out;
  logic [ADDR_W-1:0] ram_add;
  logic              ram_read, ram_write, ram_en;
  logic [ADDR_W:0]   level;
  logic              full, empty;

  ram8_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .s(bus),
    .ram_in(ram_in), .ram_out(ram_out), .ram_add(ram_add),
    .ram_read(ram_read), .ram_write(ram_write), .ram_en(ram_en),
    .level(level), .full(full), .empty(empty)
  );

  // Behavioural 8x16 single-port RAM: combinational read, write on rising edge.
  logic [DATA_W-1:0] mem [8];
  assign ram_out = (ram_read && ram_en) ? mem[ram_add] : 16'hDEAD;
  always @(posedge clk) if (ram_write && ram_en) mem[ram_add] <= ram_in;

  int total = 0;
  int bad = 0;
  logic [DATA_W-1:0] model[$];
  int wr_n = 0, rd_n = 0, out_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: samples on the falling edge, just before the handshakes resolve.
  always @(negedge clk) begin
    int held;
    check("rw_excl", {31'd0, ram_read & ram_write}, 0);
    if (reset) begin
      check("rst_in_ready", {31'd0, bus.in_ready}, 0);
      check("rst_strobes", {29'd0, ram_en, ram_read, ram_write}, 0);
      model.delete();
      wr_n = 0;
      rd_n = 0;
    end else begin
      held = model.size() - int'(bus.out_valid);
      check("level", {28'd0, level}, model.size());
      check("empty", {31'd0, empty}, {31'd0, model.size() == 0});
      check("full", {31'd0, full}, {31'd0, held == 8});
      check("ram_in", {16'd0, ram_in}, {16'd0, bus.in_data});
      check("in_ready_wr", {31'd0, bus.in_ready & ~ram_write}, 0);
      if (ram_write) begin
        check("wr_add", {29'd0, ram_add}, wr_n % 8);
        check("wr_en", {31'd0, ram_en}, 1);
        wr_n++;
      end
      if (ram_read) begin
        check("rd_add", {29'd0, ram_add}, rd_n % 8);
        check("rd_en", {31'd0, ram_en}, 1);
        rd_n++;
      end
      if (bus.in_valid && bus.in_ready) model.push_back(bus.in_data);
      if (bus.out_valid && bus.out_ready) begin
        if (model.size() == 0) check("pop_empty", 1, 0);
        else check("out_data", {16'd0, bus.out_data}, {16'd0, model.pop_front()});
        out_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, n, base, sent;
    logic prev_w;
    bit first, done;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    // Single word: write at 0, fetch at 0, visible two cycles after acceptance.
    bus.in_data = 16'h1111;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("t1_wr", {27'd0, ram_write, ram_read, ram_add}, {27'd0, 1'b1, 1'b0, 3'd0});
    check("t1_rdy", {31'd0, bus.in_ready}, 1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t1_rd", {27'd0, ram_write, ram_read, ram_add}, {27'd0, 1'b0, 1'b1, 3'd0});
    check("t1_vld0", {31'd0, bus.out_valid}, 0);
    tick();
    @(negedge clk);
    check("t1_out", {15'd0, bus.out_valid, bus.out_data}, {15'd0, 1'b1, 16'h1111});
    check("t1_level", {28'd0, level}, 1);

    // Fill to capacity with the consumer stalled.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    acc = 0;
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0001;
    for (int c = 0; c < 40 && acc < 9; c++) begin
      @(negedge clk);
      if (bus.in_ready) acc++;
      tick();
      bus.in_data = 16'(acc + 1);
    end
    bus.in_data = 16'h000A;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t2_no_accept", {31'd0, bus.in_ready}, 0);
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t2_accepted", acc, 9);
    check("t2_full", {31'd0, full}, 1);
    check("t2_level", {28'd0, level}, 9);
    check("t2_head", {16'd0, bus.out_data}, 16'h0001);

    // Drain at full rate.
    tick();
    bus.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (empty) break;
      check("t3_cont", {31'd0, bus.out_valid}, 1);
      if (bus.out_valid) begin
        check("t3_data", {16'd0, bus.out_data}, n + 1);
        n++;
      end
      tick();
    end
    check("t3_count", n, 9);
    check("t3_empty", {31'd0, empty}, 1);
    tick();
    bus.out_ready = 1'b0;

    // Contention: both sides busy, grants must alternate.
    bus.in_valid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      bus.in_data = 16'($urandom);
      @(negedge clk);
      if (level >= 3) done = 1'b1;
      tick();
    end
    check("t4_prefill", {31'd0, done}, 1);
    bus.out_ready = 1'b1;
    first = 1'b1;
    prev_w = 1'b0;
    for (int c = 0; c < 24; c++) begin
      bus.in_data = 16'($urandom);
      @(negedge clk);
      check("t4_one_access", {31'd0, ram_write ^ ram_read}, 1);
      if (!first) check("t4_alternate", {31'd0, ram_write}, {31'd0, ~prev_w});
      check("t4_level_band", {31'd0, level >= 3 && level <= 5}, 1);
      prev_w = ram_write;
      first = 1'b0;
      tick();
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 40 && !empty; c++) tick();
    @(negedge clk);
    check("t4_drained", {31'd0, empty}, 1);
    tick();

    // Random streaming across several pointer wraps.
    base = out_cnt;
    sent = 0;
    bus.in_data = 16'h0100;
    for (int c = 0; c < 600 && (out_cnt - base) < 20; c++) begin
      bus.in_valid = (sent < 20) ? 1'($urandom % 2) : 1'b0;
      bus.out_ready = 1'($urandom % 2);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
      bus.in_data = 16'(16'h0100 + sent);
    end
    check("t5_sent", sent, 20);
    check("t5_received", out_cnt - base, 20);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Reset in the middle of a stream.
    bus.in_valid = 1'b1;
    for (int c = 0; c < 40 && level < 5; c++) begin
      bus.in_data = 16'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t6_prefill", {31'd0, level >= 5}, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_level", {28'd0, level}, 0);
    check("t6_vld", {31'd0, bus.out_valid}, 0);
    check("t6_empty", {31'd0, empty}, 1);
    check("t6_strobes", {29'd0, ram_en, ram_read, ram_write}, 0);
    tick();
    bus.in_data = 16'hBEEF;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        check("t6_first_out", {16'd0, bus.out_data}, 16'hBEEF);
        done = 1'b1;
      end
      tick();
    end
    check("t6_seen", {31'd0, done}, 1);
    bus.out_ready = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
